fft_out_serializer: RTL

FFT_OUT_SERIALIZER -- requirements
Module: fft_out_serializer

---
 rtl/fft_out_serializer.sv | 108 ++++++++++
 1 files changed

// File: rtl/fft_out_serializer.sv
// Buffers up to two captured 32-bin complex FFT frames (ping-pong) and streams them
// out one bin per beat over a valid/ready interface.
module fft_out_serializer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid,
    input  logic [WIDTH*32-1:0]  real_output,
    input  logic [WIDTH*32-1:0]  imag_output,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_real,
    output logic [WIDTH-1:0]     out_imag,
    output logic [4:0]           out_index,
    output logic                 out_last,
    output logic [1:0]           frames_pending,
    output logic                 overflow
);

    typedef enum logic [0:0] {StIdle, StStream} state_e;

    state_e     state_q, state_d;
    logic       valid_q;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [4:0] idx_q, idx_d;
    logic [1:0] pending_q, pending_d;
    logic       overflow_q, overflow_d;

    logic       capture;
    logic       beat_xfer;
    logic       last_xfer;
    logic       accept;

    logic [WIDTH-1:0] buf_re [2][32];
    logic [WIDTH-1:0] buf_im [2][32];

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        idx_d      = idx_q;
        overflow_d = overflow_q;

        capture   = valid & ~valid_q;
        beat_xfer = (state_q == StStream) & out_ready;
        last_xfer = beat_xfer & (idx_q == 5'd31);
        // A slot freed by a bin-31 transfer this cycle can take the new frame at once.
        accept    = capture & ((pending_q < 2'd2) | last_xfer);

        if (accept) wr_ptr_d = ~wr_ptr_q;
        if (beat_xfer) idx_d = idx_q + 5'd1;
        if (last_xfer) rd_ptr_d = ~rd_ptr_q;
        if (capture & ~accept) overflow_d = 1'b1;

        pending_d = pending_q + {1'b0, accept} - {1'b0, last_xfer};

        unique case (state_q)
            StIdle:   if (pending_d != 2'd0) state_d = StStream;
            StStream: if (pending_d == 2'd0) state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        out_valid      = (state_q == StStream);
        out_index      = idx_q;
        out_last       = out_valid & (idx_q == 5'd31);
        frames_pending = pending_q;
        overflow       = overflow_q;
        out_real       = '0;
        out_imag       = '0;
        if (out_valid) begin
            out_real = buf_re[rd_ptr_q][idx_q];
            out_imag = buf_im[rd_ptr_q][idx_q];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            valid_q    <= 1'b0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            idx_q      <= 5'd0;
            pending_q  <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            idx_q      <= idx_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    // Frame storage is deliberately not reset; outputs are gated to zero outside STREAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int j = 0; j < 32; j++) begin
                buf_re[wr_ptr_q][j] <= real_output[j*WIDTH +: WIDTH];
                buf_im[wr_ptr_q][j] <= imag_output[j*WIDTH +: WIDTH];
            end
        end
    end

endmodule
